// File: rtl/rs_cmd_pkg.sv
// Shared command/state encodings and default timing for the gated-RS-latch command sequencer.
package rs_cmd_pkg;

  typedef enum logic [1:0] {
    CMD_HOLD    = 2'b00,
    CMD_SET     = 2'b01,
    CMD_RESET   = 2'b10,
    CMD_ILLEGAL = 2'b11
  } cmd_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SETUP = 2'd1,
    ST_PULSE = 2'd2,
    ST_HOLD  = 2'd3
  } state_e;

  localparam int CMD_W            = 2;
  localparam int DEF_SETUP_CYCLES = 1;
  localparam int DEF_ENA_CYCLES   = 2;
  localparam int DEF_HOLD_CYCLES  = 1;
  localparam int DEF_FIFO_DEPTH   = 4;

  // Latch drive as {R,S}; never returns 2'b11, so R and S cannot both be high.
  function automatic logic [1:0] rs_of(cmd_e c);
    case (c)
      CMD_SET:   return 2'b01;
      CMD_RESET: return 2'b10;
      default:   return 2'b00;
    endcase
  endfunction

endpackage

// File: rtl/rs_cmd_fifo.sv
// Command queue: power-of-two depth, pointers carry one extra wrap bit to tell full from empty.
module rs_cmd_fifo
  import rs_cmd_pkg::*;
#(
  parameter int DEPTH = DEF_FIFO_DEPTH,
  parameter int WIDTH = CMD_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             empty,
  output logic             full
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic [WIDTH-1:0] mem [DEPTH];

  assign empty    = (wr_ptr == rd_ptr);
  assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign pop_data = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push && !full)  wr_ptr <= wr_ptr + 1'b1;
      if (pop  && !empty) rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Storage carries no reset; only the pointers define what is valid.
  always_ff @(posedge clk) begin
    if (push && !full) mem[wr_ptr[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/rs_cmd_seq.sv
// Queues SET/RESET/HOLD commands and plays each as setup / enable pulse / hold on a gated RS latch.
// Optional Q readback compare is compiled in with macro RS_CMD_SEQ_READBACK_EN.
module rs_cmd_seq
  import rs_cmd_pkg::*;
#(
  parameter int SETUP_CYCLES = DEF_SETUP_CYCLES,
  parameter int ENA_CYCLES   = DEF_ENA_CYCLES,
  parameter int HOLD_CYCLES  = DEF_HOLD_CYCLES,
  parameter int FIFO_DEPTH   = DEF_FIFO_DEPTH
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       CMD_VALID,
  input  logic [1:0] CMD,
  output logic       CMD_READY,
  output logic       ENA,
  output logic       R,
  output logic       S,
  output logic       BUSY,
  output logic       ERR_ILLEGAL
`ifdef RS_CMD_SEQ_READBACK_EN
  ,
  input  logic       Q_IN,
  output logic       MISMATCH
`endif
);

  localparam int MAX_A   = (SETUP_CYCLES > ENA_CYCLES) ? SETUP_CYCLES : ENA_CYCLES;
  localparam int MAX_CYC = (MAX_A > HOLD_CYCLES) ? MAX_A : HOLD_CYCLES;
  localparam int CNT_W   = $clog2(MAX_CYC + 1);

  localparam logic [CNT_W-1:0] SETUP_LAST = CNT_W'(SETUP_CYCLES - 1);
  localparam logic [CNT_W-1:0] PULSE_LAST = CNT_W'(ENA_CYCLES - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(HOLD_CYCLES - 1);

  logic             fifo_full;
  logic             fifo_empty;
  logic [1:0]       head;
  logic             take;
  logic             push;
  logic             pop;
  logic             hold_done;
  state_e           state;
  logic [CNT_W-1:0] cnt;

  assign CMD_READY = !fifo_full;
  assign take      = CMD_VALID && !fifo_full;
  assign push      = take && (CMD != CMD_ILLEGAL);
  assign hold_done = (state == ST_HOLD) && (cnt == HOLD_LAST);
  // The head is only taken from the registered queue state, so a fresh push never bypasses it.
  assign pop       = !fifo_empty && ((state == ST_IDLE) || hold_done);

  rs_cmd_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (CMD_W)
  ) u_fifo (
    .clk       (CLK),
    .rst       (RST),
    .push      (push),
    .push_data (CMD),
    .pop       (pop),
    .pop_data  (head),
    .empty     (fifo_empty),
    .full      (fifo_full)
  );

  always_ff @(posedge CLK) begin
    if (RST) begin
      state       <= ST_IDLE;
      cnt         <= '0;
      ENA         <= 1'b0;
      R           <= 1'b0;
      S           <= 1'b0;
      BUSY        <= 1'b0;
      ERR_ILLEGAL <= 1'b0;
    end else begin
      ERR_ILLEGAL <= take && (CMD == CMD_ILLEGAL);
      cnt         <= cnt + 1'b1;
      case (state)
        ST_IDLE: begin
          cnt <= '0;
          if (pop) begin
            state  <= ST_SETUP;
            {R, S} <= rs_of(cmd_e'(head));
            BUSY   <= 1'b1;
          end else begin
            BUSY <= push;
          end
        end
        ST_SETUP: begin
          if (cnt == SETUP_LAST) begin
            state <= ST_PULSE;
            cnt   <= '0;
            ENA   <= 1'b1;
          end
        end
        ST_PULSE: begin
          if (cnt == PULSE_LAST) begin
            state <= ST_HOLD;
            cnt   <= '0;
            ENA   <= 1'b0;
          end
        end
        ST_HOLD: begin
          if (hold_done) begin
            cnt <= '0;
            if (!fifo_empty) begin
              state  <= ST_SETUP;
              {R, S} <= rs_of(cmd_e'(head));
            end else begin
              state  <= ST_IDLE;
              {R, S} <= 2'b00;
              BUSY   <= push;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

`ifdef RS_CMD_SEQ_READBACK_EN
  logic exp_q;
  logic exp_vld;

  // Compare on the first HOLD cycle; R/S still show the command being completed.
  always_ff @(posedge CLK) begin
    if (RST) begin
      exp_q    <= 1'b0;
      exp_vld  <= 1'b0;
      MISMATCH <= 1'b0;
    end else begin
      MISMATCH <= 1'b0;
      if (state == ST_HOLD && cnt == '0) begin
        if (S) begin
          MISMATCH <= (Q_IN != 1'b1);
          exp_q    <= 1'b1;
          exp_vld  <= 1'b1;
        end else if (R) begin
          MISMATCH <= (Q_IN != 1'b0);
          exp_q    <= 1'b0;
          exp_vld  <= 1'b1;
        end else if (exp_vld) begin
          MISMATCH <= (Q_IN != exp_q);
        end
      end
    end
  end
`endif

endmodule

// File: doc/rs_cmd_seq.md
RS_CMD_SEQ -- requirements
Module: rs_cmd_seq

Interface
REQ-001 Parameter SETUP_CYCLES, default 1: cycles R/S are held stable with ENA low before the enable pulse; minimum 1.
REQ-002 Parameter ENA_CYCLES, default 2: width of the ENA pulse in cycles; minimum 1.
REQ-003 Parameter HOLD_CYCLES, default 1: cycles R/S are held stable after ENA falls; minimum 1.
REQ-004 Parameter FIFO_DEPTH, default 4: command queue depth; power of two, minimum 2.
REQ-005 CLK  in  1  single clock; all state updates on the rising edge.
REQ-006 RST  in  1  reset, synchronous, active-high.
REQ-007 CMD_VALID  in  1  command offered this cycle.
REQ-008 CMD  in  2  command code: 00 HOLD, 01 SET, 10 RESET, 11 illegal.
REQ-009 CMD_READY  out  1  queue can accept; a transfer occurs when CMD_VALID and CMD_READY are both high.
REQ-010 ENA  out  1  gate enable to the downstream gated RS latch.
REQ-011 R  out  1  latch reset input.
REQ-012 S  out  1  latch set input.
REQ-013 BUSY  out  1  high when the FSM is not IDLE or the queue is non-empty.
REQ-014 ERR_ILLEGAL  out  1  one-cycle pulse when an illegal command is accepted.

Function
REQ-015 All outputs SHALL be registered, except CMD_READY, which SHALL equal NOT queue-full.
REQ-016 Accepted legal commands SHALL be enqueued in FIFO order.
REQ-017 Code 11 SHALL be accepted, SHALL NOT be enqueued, and SHALL pulse ERR_ILLEGAL on the next cycle.
REQ-018 FSM states SHALL be IDLE, SETUP, PULSE and HOLD.
REQ-019 IDLE with a non-empty queue SHALL pop the head and go to SETUP; IDLE with an empty queue SHALL stay in IDLE.
REQ-020 SETUP -> PULSE after SETUP_CYCLES cycles; PULSE -> HOLD after ENA_CYCLES cycles.
REQ-021 HOLD SHALL last HOLD_CYCLES cycles, then pop and go to SETUP if the queue is non-empty, else go to IDLE.
REQ-022 In SETUP, PULSE and HOLD, {R,S} SHALL be driven as SET=01, RESET=10, HOLD=00 and SHALL stay constant for the whole command.
REQ-023 ENA SHALL be 1 only in PULSE.
REQ-024 In IDLE, ENA, R and S SHALL all be 0.
REQ-025 R and S SHALL never both be 1 in any cycle.
REQ-026 With an idle FSM and an empty queue, a command accepted at edge N SHALL drive R/S from edge N+1, and ENA SHALL rise at edge N+1+SETUP_CYCLES.
REQ-027 Back-to-back commands SHALL each occupy exactly SETUP_CYCLES+ENA_CYCLES+HOLD_CYCLES cycles with no IDLE gap between them.
REQ-028 When the queue is full, CMD_READY SHALL be low; a pop in the same cycle SHALL NOT raise CMD_READY until the next cycle.
REQ-029 With an empty queue, a push and the pop in that same cycle SHALL NOT bypass the queue; latency stays as in REQ-026.
REQ-030 Queue pointers SHALL wrap modulo FIFO_DEPTH, with one extra bit used to distinguish full from empty.

Reset
REQ-031 While RST is high at an edge: FSM -> IDLE, queue emptied, counters cleared.
REQ-032 Reset values SHALL be ENA=0, R=0, S=0, BUSY=0, ERR_ILLEGAL=0, CMD_READY=1 (and MISMATCH=0 when compiled in).
REQ-033 Reset during PULSE SHALL drop ENA to 0 at that edge; the in-flight command and all queued commands are discarded.

Configuration
REQ-034 With macro RS_CMD_SEQ_READBACK_EN defined, the block SHALL add input Q_IN (in, 1, downstream latch Q) and output MISMATCH (out, 1).
REQ-035 With the macro defined, on the first HOLD cycle the block SHALL compare Q_IN against the expected value: 1 after SET, 0 after RESET, the previous expected value after HOLD.
REQ-036 MISMATCH SHALL pulse for one cycle on the following cycle if the compare fails.
REQ-037 The compare for a HOLD command SHALL be skipped until a SET or RESET has completed since reset.
REQ-038 Without the macro, Q_IN, MISMATCH and the expected-value register SHALL NOT exist.

Structure
REQ-039 Package rs_cmd_pkg SHALL hold the 2-bit command encodings, the FSM state encoding and the default parameter constants.
REQ-040 The command queue SHALL be sub-module rs_cmd_fifo (parameterised depth, width 2).
REQ-041 The FSM and pulse counters SHALL reside in rs_cmd_seq.

Verification (defaults SETUP=1, ENA=2, HOLD=1, DEPTH=4)
REQ-042 SET accepted at edge 0 -> S=1,R=0 at edges 1-4; ENA=1 at edges 2-3; all outputs 0 from edge 5; BUSY low at edge 5.
REQ-043 SET, RESET, HOLD sent back-to-back -> {R,S}=01 for 4 cycles, 10 for 4 cycles, 00 for 4 cycles; ENA pulses 2 cycles each; no gap; R&S never 1.
REQ-044 6 commands offered continuously while the first executes -> CMD_READY drops after 5 accepts (4 queued + 1 popped); all accepted commands execute in order; none lost.
REQ-045 CMD=11 with CMD_VALID=1 -> ERR_ILLEGAL=1 for exactly one cycle; queue depth unchanged; ENA stays 0.
REQ-046 RST asserted on the second PULSE cycle with 2 commands queued -> ENA, R, S = 0 at that edge; BUSY=0; CMD_READY=1; no further pulses.
REQ-047 With RS_CMD_SEQ_READBACK_EN, SET executed while Q_IN is held at 0 -> MISMATCH=1 for one cycle at edge 5; RESET with Q_IN=0 -> MISMATCH stays 0.
